// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU: iterative shifter, optional shift-add multiplier (ALU_MUL_EN)
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);
    localparam int CW = SHW + 1;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL, S_DONE} state_t;
    typedef enum logic [3:0] {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_LLS, K_LRS, K_MUL, K_ILL} kind_t;

    function automatic kind_t decode(input logic [1:0] o, input logic [3:0] f);
        kind_t k;
        k = K_ILL;
        case (o)
            2'b00: k = K_ADD;
            2'b01: k = K_SUB;
            2'b10: begin
                case (f)
                    4'b0000: k = K_ADD;
                    4'b1000: k = K_SUB;
                    4'b0111: k = K_AND;
                    4'b0110: k = K_OR;
                    4'b0100: k = K_XOR;
                    4'b0001: k = K_LLS;
                    4'b0101: k = K_LRS;
`ifdef ALU_MUL_EN
                    4'b0010: k = K_MUL;
`endif
                    default: k = K_ILL;
                endcase
            end
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    state_t           state_q;
    kind_t            kind_q;
    kind_t            in_kind;
    logic [WIDTH-1:0] a_q, b_q, work_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q, n_q, c_q, v_q, err_q, out_valid_q;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sh_next, fin_res;
    logic             sh_out, fin_c, fin_v, fin_err;
    logic [SHW-1:0]   in_amt;

    assign in_kind = decode(op, func);
    assign in_amt  = b[SHW-1:0];
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    assign sh_next = (kind_q == K_LLS) ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    assign sh_out  = (kind_q == K_LLS) ? work_q[WIDTH-1] : work_q[0];

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, mpl_q, hi_q, fin_hi;
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, a_q} : '0);
    assign hi      = hi_q;
`else
    assign hi      = '0;
`endif

    // Value that will be committed to the output registers when DONE is entered
    always_comb begin
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_err = 1'b0;
`ifdef ALU_MUL_EN
        fin_hi  = '0;
`endif
        case (state_q)
            S_SHIFT: begin
                fin_res = sh_next;
                fin_c   = sh_out;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                fin_res = {mul_sum[0], mpl_q[WIDTH-1:1]};
                fin_hi  = mul_sum[WIDTH:1];
                fin_c   = (mul_sum[WIDTH:1] != '0);
            end
`endif
            default: begin
                case (kind_q)
                    K_ADD: begin
                        fin_res = sum[WIDTH-1:0];
                        fin_c   = sum[WIDTH];
                        fin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    K_SUB: begin
                        fin_res = diff[WIDTH-1:0];
                        fin_c   = diff[WIDTH];
                        fin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    K_AND:        fin_res = a_q & b_q;
                    K_OR:         fin_res = a_q | b_q;
                    K_XOR:        fin_res = a_q ^ b_q;
                    K_LLS, K_LRS: fin_res = a_q;   // zero shift amount
                    default:      fin_err = 1'b1;
                endcase
            end
        endcase
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_ADD;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q       <= '0;
            mpl_q       <= '0;
            hi_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        kind_q <= in_kind;
                        a_q    <= a;
                        b_q    <= b;
                        work_q <= a;
                        cnt_q  <= CW'(in_amt);
`ifdef ALU_MUL_EN
                        acc_q  <= '0;
                        mpl_q  <= b;
`endif
                        if ((in_kind == K_LLS || in_kind == K_LRS) && in_amt != '0) begin
                            state_q <= S_SHIFT;
                        end else if (in_kind == K_MUL) begin
                            cnt_q   <= CW'(WIDTH);
                            state_q <= S_MUL;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_SHIFT, S_MUL, S_EXEC: begin
                    work_q <= sh_next;
                    cnt_q  <= cnt_q - 1'b1;
`ifdef ALU_MUL_EN
                    acc_q  <= mul_sum[WIDTH:1];
                    mpl_q  <= {mul_sum[0], mpl_q[WIDTH-1:1]};
`endif
                    if (state_q == S_EXEC || cnt_q == CW'(1)) begin
                        result_q    <= fin_res;
                        z_q         <= (fin_res == '0);
                        n_q         <= fin_res[WIDTH-1];
                        c_q         <= fin_c;
                        v_q         <= fin_v;
                        err_q       <= fin_err;
`ifdef ALU_MUL_EN
                        hi_q        <= fin_hi;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed checks of alu_exec_unit against a reference model
module tb_alu_exec_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = '0;
    logic [3:0] func = '0;
    logic [7:0] a = '0, b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result, hi;
    logic       flag_z, flag_n, flag_c, flag_v, err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .func(func), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    // 0 add 1 sub 2 and 3 or 4 xor 5 lls 6 lrs 7 mul 8 illegal
    function automatic int classify(input logic [1:0] o, input logic [3:0] f);
        if (o == 2'b00) return 0;
        if (o == 2'b01) return 1;
        if (o == 2'b11) return 8;
        case (f)
            4'b0000: return 0;
            4'b1000: return 1;
            4'b0111: return 2;
            4'b0110: return 3;
            4'b0100: return 4;
            4'b0001: return 5;
            4'b0101: return 6;
`ifdef ALU_MUL_EN
            4'b0010: return 7;
`endif
            default: return 8;
        endcase
    endfunction

    // Packed expectation: {result, hi, z, n, c, v, err}
    function automatic logic [20:0] ref_out(input logic [1:0] o, input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        int ua = x, ub = y, sa = $signed(x), sb = $signed(y);
        int r = 0, h = 0, c = 0, v = 0, e = 0, amt = y % 8;
        logic [7:0] r8, h8;
        case (classify(o, f))
            0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); r = r % 256; end
            1: begin r = (ua - ub + 256) % 256; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: begin r = (ua << amt) % 256; c = (amt != 0) ? ((ua >> (8 - amt)) & 1) : 0; end
            6: begin r = ua >> amt; c = (amt != 0) ? ((ua >> (amt - 1)) & 1) : 0; end
            7: begin r = (ua * ub) % 256; h = (ua * ub) / 256; c = (h != 0); end
            default: e = 1;
        endcase
        r8 = r[7:0];
        h8 = h[7:0];
        return {r8, h8, (r8 == 8'd0), r8[7], c[0], v[0], e[0]};
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [3:0] f, input logic [7:0] y);
        int k = classify(o, f);
        if ((k == 5 || k == 6) && (y % 8) != 0) return (y % 8) + 1;
        if (k == 7) return 9;
        return 2;
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL start_wait: in_ready=%0b required 1", in_ready);
        end
        op = o; func = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [20:0] obs, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        obs = {result, hi, flag_z, flag_n, flag_c, flag_v, err};
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, result, hi, flag_z, flag_n, flag_c, flag_v, err} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, result, hi, flag_z, flag_n, flag_c, flag_v, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_add_overflow;
        logic [20:0] obs;
        int lat;
        start_op(2'b10, 4'b0000, 8'h7F, 8'h01);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== {8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL add_overflow: got %h required %h", obs, {8'h80, 8'h00, 5'b01010});
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL add_latency: got %0d required 2", lat);
        end
    endtask

    task automatic test_sub_compare;
        logic [20:0] obs;
        int lat;
        start_op(2'b01, 4'b0000, 8'h05, 8'h09);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== ref_out(2'b01, 4'b0000, 8'h05, 8'h09) || obs[20:13] !== 8'hFC || obs[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_borrow: got %h required %h", obs, ref_out(2'b01, 4'b0000, 8'h05, 8'h09));
        end
        start_op(2'b01, 4'b0000, 8'h33, 8'h33);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== ref_out(2'b01, 4'b0000, 8'h33, 8'h33) || obs[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_equal: got %h required %h", obs, ref_out(2'b01, 4'b0000, 8'h33, 8'h33));
        end
    endtask

    task automatic test_backpressure;
        logic [20:0] obs, now;
        int lat;
        logic seen;
        start_op(2'b10, 4'b0101, 8'hB1, 8'h03);
        wait_done(obs, lat);
        n_cmp++;
        if (obs !== ref_out(2'b10, 4'b0101, 8'hB1, 8'h03) || obs[20:13] !== 8'h16) begin
            n_bad++;
            $display("FAIL lrs_value: got %h required %h", obs, ref_out(2'b10, 4'b0101, 8'hB1, 8'h03));
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL lrs_latency: got %0d required 4", lat);
        end
        op = 2'b00; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            now = {result, hi, flag_z, flag_n, flag_c, flag_v, err};
            n_cmp++;
            if (now !== obs || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable: got %h v=%0b rdy=%0b required %h v=1 rdy=0", now, out_valid, in_ready, obs);
            end
        end
        in_valid = 1'b0;
        finish_op();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignored: out_valid seen=%0b required 0", seen);
        end
    endtask

    task automatic test_mul;
        logic [20:0] obs;
        int lat;
        start_op(2'b10, 4'b0010, 8'hFF, 8'hFF);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== ref_out(2'b10, 4'b0010, 8'hFF, 8'hFF)) begin
            n_bad++;
            $display("FAIL mul_ff: got %h required %h", obs, ref_out(2'b10, 4'b0010, 8'hFF, 8'hFF));
        end
        n_cmp++;
        if (lat != ref_lat(2'b10, 4'b0010, 8'hFF)) begin
            n_bad++;
            $display("FAIL mul_latency: got %0d required %0d", lat, ref_lat(2'b10, 4'b0010, 8'hFF));
        end
    endtask

    task automatic test_illegal;
        logic [20:0] obs;
        int lat;
        start_op(2'b11, 4'b0000, 8'h5A, 8'hA5);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== {16'h0000, 5'b10001} || lat != 2) begin
            n_bad++;
            $display("FAIL illegal_op11: got %h lat=%0d required %h lat=2", obs, lat, {16'h0000, 5'b10001});
        end
        start_op(2'b10, 4'b1111, 8'h12, 8'h34);
        wait_done(obs, lat);
        finish_op();
        n_cmp++;
        if (obs !== {16'h0000, 5'b10001} || lat != 2) begin
            n_bad++;
            $display("FAIL illegal_f15: got %h lat=%0d required %h lat=2", obs, lat, {16'h0000, 5'b10001});
        end
    endtask

    task automatic test_reset_mid_shift;
        logic seen;
        start_op(2'b10, 4'b0001, 8'h81, 8'h07);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, result, hi, flag_z, flag_n, flag_c, flag_v, err} !== 22'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h required 0", {out_valid, result, hi, flag_z, flag_n, flag_c, flag_v, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_in_ready: got %0b required 1", in_ready);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_output: out_valid seen=%0b required 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ftab [8] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b0010};
        logic [20:0] obs, exp;
        logic [1:0]  o;
        logic [3:0]  f;
        logic [7:0]  x, y;
        int lat;
        for (int i = 0; i < 80; i++) begin
            o = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ftab[$urandom_range(0, 7)];
            x = 8'($urandom);
            y = 8'($urandom);
            start_op(o, f, x, y);
            wait_done(obs, lat);
            finish_op();
            exp = ref_out(o, f, x, y);
            n_cmp++;
            if (obs !== exp || lat != ref_lat(o, f, y)) begin
                n_bad++;
                $display("FAIL random_%0d op=%b func=%b a=%h b=%h: got %h lat=%0d required %h lat=%0d",
                         i, o, f, x, y, obs, lat, exp, ref_lat(o, f, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_compare();
        test_backpressure();
        test_mul();
        test_illegal();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
